// File: rtl/npu_simple.sv
// Byte-addressed 8x82 scratch memory feeding a 9-lane x 8-channel MAC array
// with a three-stage pipeline: operand capture, accumulate, shift/pool/saturate.
module npu_simple (
    input  logic        clk,
    input  logic        reset,
    input  logic [6:0]  write_w,
    input  logic [2:0]  write_h,
    input  logic [71:0] data_in,
    input  logic [8:0]  en_in,
    input  logic [62:0] readi_w,
    input  logic [26:0] readi_h,
    input  logic [8:0]  en_read,
    input  logic        en_bias,
    input  logic [2:0]  step,
    input  logic        en_pe,
    input  logic [2:0]  bound_level,
    input  logic [2:0]  step_p,
    input  logic        en_relu,
    input  logic        en_mp,
    output logic [63:0] out,
    output logic [7:0]  out_en
);

    logic        [7:0]  r_mem [0:7][0:81];

    logic        [7:0]  w_wcol [0:8];
    logic        [6:0]  w_rcol [0:8];
    logic        [2:0]  w_rrow [0:8];
    logic        [7:0]  w_a    [0:8];

    logic               r_s1_valid;
    logic        [7:0]  r_a    [0:8];
    logic signed [7:0]  r_w    [0:7][0:8];
    logic signed [15:0] r_bias [0:7];
    logic               r_s1_bias_en;
    logic        [2:0]  r_s1_step;
    logic        [2:0]  r_s1_step_p;
    logic        [2:0]  r_s1_bound;
    logic               r_s1_relu;
    logic               r_s1_mp;

    logic signed [23:0] w_sum  [0:7];
    logic signed [23:0] w_new  [0:7];
    logic signed [23:0] r_acc  [0:7];

    logic               r_s2_valid;
    logic signed [23:0] r_s2_val [0:7];
    logic        [2:0]  r_s2_bound;
    logic               r_s2_relu;
    logic               r_s2_mp;

    logic signed [23:0] w_v    [0:7];
    logic signed [23:0] w_pre  [0:7];
    logic signed [23:0] r_held [0:7];
    logic               r_mp_toggle;

    function automatic logic [7:0] sat8(input logic signed [23:0] v, input logic relu);
        logic [7:0] res;
        if (relu) begin
            if (v < 0)                res = 8'h00;
            else if (v > 24'sd255)    res = 8'hFF;
            else                      res = v[7:0];
        end else begin
            if (v < -24'sd128)        res = 8'h80;
            else if (v > 24'sd127)    res = 8'h7F;
            else                      res = v[7:0];
        end
        return res;
    endfunction

    always_comb begin
        for (int unsigned j = 0; j < 9; j++) begin
            w_wcol[j] = {1'b0, write_w} + 8'(j);
            w_rcol[j] = readi_w[62-7*j -: 7];
            w_rrow[j] = readi_h[26-3*j -: 3];
            w_a[j]    = '0;
            if (en_read[8-j] && (w_rcol[j] < 7'd82))
                w_a[j] = r_mem[w_rrow[j]][w_rcol[j]];
        end
    end

    // Memory is never reset; columns past 81 are silently dropped.
    always_ff @(posedge clk) begin
        for (int unsigned j = 0; j < 9; j++) begin
            if (en_in[8-j] && (w_wcol[j] < 8'd82))
                r_mem[write_h][w_wcol[j][6:0]] <= data_in[71-8*j -: 8];
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_s1_valid <= 1'b0;
        end else begin
            r_s1_valid <= en_pe;
            if (en_pe) begin
                for (int unsigned j = 0; j < 9; j++)
                    r_a[j] <= w_a[j];
                for (int unsigned r = 0; r < 8; r++) begin
                    for (int unsigned j = 0; j < 9; j++)
                        r_w[r][j] <= r_mem[r][7'(71 + j)];
                    r_bias[r] <= {r_mem[r][80], r_mem[r][81]};
                end
                r_s1_bias_en <= en_bias;
                r_s1_step    <= step;
                r_s1_step_p  <= step_p;
                r_s1_bound   <= bound_level;
                r_s1_relu    <= en_relu;
                r_s1_mp      <= en_mp;
            end
        end
    end

    always_comb begin
        for (int unsigned r = 0; r < 8; r++) begin
            w_sum[r] = '0;
            for (int unsigned j = 0; j < 9; j++)
                w_sum[r] = w_sum[r] + 24'(signed'({1'b0, r_a[j]})) * 24'(r_w[r][j]);
            if (r_s1_step == 3'd0)
                w_new[r] = w_sum[r] + (r_s1_bias_en ? 24'(r_bias[r]) : 24'sd0);
            else
                w_new[r] = r_acc[r] + w_sum[r];
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_s2_valid <= 1'b0;
            for (int unsigned r = 0; r < 8; r++)
                r_acc[r] <= '0;
        end else begin
            r_s2_valid <= r_s1_valid && (r_s1_step == r_s1_step_p);
            if (r_s1_valid) begin
                for (int unsigned r = 0; r < 8; r++) begin
                    r_acc[r]    <= w_new[r];
                    r_s2_val[r] <= w_new[r];
                end
                r_s2_bound <= r_s1_bound;
                r_s2_relu  <= r_s1_relu;
                r_s2_mp    <= r_s1_mp;
            end
        end
    end

    always_comb begin
        for (int unsigned r = 0; r < 8; r++) begin
            w_v[r]   = r_s2_val[r] >>> r_s2_bound;
            w_pre[r] = w_v[r];
            if (r_s2_mp && (r_held[r] > w_v[r]))
                w_pre[r] = r_held[r];
        end
    end

    // With pooling on, the first final of each pair only parks its value in r_held.
    always_ff @(posedge clk) begin
        if (reset) begin
            out         <= '0;
            out_en      <= '0;
            r_mp_toggle <= 1'b0;
            for (int unsigned r = 0; r < 8; r++)
                r_held[r] <= '0;
        end else begin
            out_en <= '0;
            if (r_s2_valid) begin
                if (r_s2_mp && !r_mp_toggle) begin
                    r_mp_toggle <= 1'b1;
                    for (int unsigned r = 0; r < 8; r++)
                        r_held[r] <= w_v[r];
                end else begin
                    r_mp_toggle <= 1'b0;
                    out_en      <= '1;
                    for (int unsigned r = 0; r < 8; r++)
                        out[63-8*r -: 8] <= sat8(w_pre[r], r_s2_relu);
                end
            end else if (!r_s2_mp) begin
                r_mp_toggle <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_npu_simple.sv
// Directed bench for npu_simple: hand-computed channel-0 results, other channels
// have zero weights/bias so they are expected to read 0.
module tb_npu_simple;

    logic        clk = 1'b0;
    logic        reset;
    logic [6:0]  write_w;
    logic [2:0]  write_h;
    logic [71:0] data_in;
    logic [8:0]  en_in;
    logic [62:0] readi_w;
    logic [26:0] readi_h;
    logic [8:0]  en_read;
    logic        en_bias;
    logic [2:0]  step;
    logic        en_pe;
    logic [2:0]  bound_level;
    logic [2:0]  step_p;
    logic        en_relu;
    logic        en_mp;
    logic [63:0] out;
    logic [7:0]  out_en;

    int unsigned n_checks = 0;
    int unsigned n_fail   = 0;

    always #5 clk = ~clk;

    npu_simple dut (
        .clk(clk), .reset(reset),
        .write_w(write_w), .write_h(write_h), .data_in(data_in), .en_in(en_in),
        .readi_w(readi_w), .readi_h(readi_h), .en_read(en_read),
        .en_bias(en_bias), .step(step), .en_pe(en_pe), .bound_level(bound_level),
        .step_p(step_p), .en_relu(en_relu), .en_mp(en_mp),
        .out(out), .out_en(out_en)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [62:0] mk_rw(input logic [6:0] base);
        logic [62:0] v;
        v = '0;
        for (int j = 0; j < 9; j++)
            v[62-7*j -: 7] = base + 7'(j);
        return v;
    endfunction

    // Called at a negedge; returns at the following negedge.
    task automatic wr(input logic [2:0] row, input logic [6:0] base,
                      input logic [71:0] d, input logic [8:0] en);
        write_h = row; write_w = base; data_in = d; en_in = en;
        @(negedge clk);
        en_in = '0;
    endtask

    task automatic op(input logic [2:0] st, input logic [2:0] stp, input logic eb,
                      input logic [2:0] bl, input logic relu, input logic mp,
                      input logic [6:0] rbase, input logic [8:0] ren);
        step = st; step_p = stp; en_bias = eb; bound_level = bl;
        en_relu = relu; en_mp = mp; readi_w = mk_rw(rbase); readi_h = '0;
        en_read = ren; en_pe = 1'b1;
        @(negedge clk);
        en_pe = 1'b0;
    endtask

    // The last op's capture edge has passed; result must appear two edges later, not one.
    task automatic expect_out(input string tag, input logic [7:0] ch0);
        @(negedge clk);
        check({tag, "_early"}, {56'h0, out_en}, 64'h0);
        @(negedge clk);
        check({tag, "_en"}, {56'h0, out_en}, 64'hFF);
        check({tag, "_val"}, out, {ch0, 56'h0});
    endtask

    initial begin
        reset = 1'b1; write_w = '0; write_h = '0; data_in = '0; en_in = '0;
        readi_w = '0; readi_h = '0; en_read = '0; en_bias = 1'b0; step = '0;
        en_pe = 1'b0; bound_level = '0; step_p = '0; en_relu = 1'b0; en_mp = 1'b0;
        repeat (2) @(negedge clk);
        check("reset_out", out, 64'h0);
        check("reset_en", {56'h0, out_en}, 64'h0);
        reset = 1'b0;

        for (int r = 0; r < 8; r++) begin
            wr(3'(r), 7'd71, '0, 9'h1FF);
            wr(3'(r), 7'd80, '0, 9'h180);
        end
        wr(3'd0, 7'd71, {9{8'h01}}, 9'h1FF);
        wr(3'd0, 7'd80, {8'h00, 8'h10, 56'h0}, 9'h180);
        wr(3'd0, 7'd0,  {9{8'h02}}, 9'h1FF);
        wr(3'd0, 7'd9,  {8'd5, 8'd9, 56'h0}, 9'h180);
        wr(3'd0, 7'd20, {9{8'd100}}, 9'h1FF);

        // 9*2*1 + 16 = 34
        op(3'd0, 3'd0, 1'b1, 3'd0, 1'b0, 1'b0, 7'd0, 9'h1FF);
        expect_out("basic", 8'h22);
        op(3'd0, 3'd0, 1'b1, 3'd2, 1'b0, 1'b0, 7'd0, 9'h1FF);
        expect_out("shift2", 8'h08);
        op(3'd0, 3'd1, 1'b0, 3'd0, 1'b0, 1'b0, 7'd0, 9'h1FF);
        op(3'd1, 3'd1, 1'b0, 3'd0, 1'b0, 1'b0, 7'd0, 9'h1FF);
        expect_out("two_step", 8'h24);
        op(3'd0, 3'd0, 1'b0, 3'd0, 1'b0, 1'b0, 7'd0, 9'h0FF);
        expect_out("lane0_off", 8'h10);

        wr(3'd0, 7'd82, {9{8'hAA}}, 9'h1FF);
        wr(3'd0, 7'd80, {8'h00, 8'h10, {7{8'h77}}}, 9'h1FF);
        op(3'd0, 3'd0, 1'b1, 3'd0, 1'b0, 1'b0, 7'd0, 9'h1FF);
        expect_out("col82_ignored", 8'h22);

        // 9*100*1 = 900
        op(3'd0, 3'd0, 1'b0, 3'd0, 1'b0, 1'b0, 7'd20, 9'h1FF);
        expect_out("sat_pos", 8'h7F);
        op(3'd0, 3'd0, 1'b0, 3'd0, 1'b1, 1'b0, 7'd20, 9'h1FF);
        expect_out("relu_pos", 8'hFF);

        wr(3'd0, 7'd71, {9{8'hFF}}, 9'h1FF);
        op(3'd0, 3'd0, 1'b0, 3'd0, 1'b0, 1'b0, 7'd20, 9'h1FF);
        expect_out("sat_neg", 8'h80);
        op(3'd0, 3'd0, 1'b0, 3'd0, 1'b1, 1'b0, 7'd20, 9'h1FF);
        expect_out("relu_neg", 8'h00);
        // -900 >>> 3 = -113
        op(3'd0, 3'd0, 1'b0, 3'd3, 1'b0, 1'b0, 7'd20, 9'h1FF);
        expect_out("neg_shift", 8'h8F);

        wr(3'd0, 7'd71, {9{8'h01}}, 9'h1FF);
        op(3'd0, 3'd0, 1'b0, 3'd0, 1'b0, 1'b1, 7'd9, 9'h100);
        op(3'd0, 3'd0, 1'b0, 3'd0, 1'b0, 1'b1, 7'd10, 9'h100);
        expect_out("mp_5_9", 8'h09);
        op(3'd0, 3'd0, 1'b0, 3'd0, 1'b0, 1'b1, 7'd10, 9'h100);
        op(3'd0, 3'd0, 1'b0, 3'd0, 1'b0, 1'b1, 7'd9, 9'h100);
        expect_out("mp_9_5", 8'h09);
        @(negedge clk);
        check("mp_single_pulse", {56'h0, out_en}, 64'h0);
        op(3'd0, 3'd0, 1'b1, 3'd0, 1'b0, 1'b0, 7'd0, 9'h1FF);
        expect_out("mp_off", 8'h22);

        op(3'd0, 3'd1, 1'b1, 3'd0, 1'b0, 1'b0, 7'd0, 9'h1FF);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        check("rst_mid_out", out, 64'h0);
        check("rst_mid_en", {56'h0, out_en}, 64'h0);
        op(3'd1, 3'd1, 1'b0, 3'd0, 1'b0, 1'b0, 7'd0, 9'h1FF);
        expect_out("acc_cleared", 8'h12);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/npu_simple.md
NPU_SIMPLE -- requirements
Module: npu_simple

Interface
REQ-001 SHALL have no parameters; all sizes are fixed: 8 rows x 82 byte columns of storage, 9 lanes, 8 output channels.
REQ-002 SHALL have one clock; reset is synchronous and active-high. Ports are named clk and reset.
REQ-003 clk  in  1  rising-edge clock.
REQ-004 reset  in  1  synchronous active-high reset.
REQ-005 write_w  in  7  write base column.
REQ-006 write_h  in  3  write row.
REQ-007 data_in  in  72  write bytes; lane j = data_in[71-8j -: 8].
REQ-008 en_in  in  9  per-lane write enable; lane j = en_in[8-j].
REQ-009 readi_w  in  63  per-lane read column; lane j = readi_w[62-7j -: 7].
REQ-010 readi_h  in  27  per-lane read row; lane j = readi_h[26-3j -: 3].
REQ-011 en_read  in  9  per-lane read enable; lane j = en_read[8-j].
REQ-012 en_bias  in  1  add the channel bias at step 0.
REQ-013 step  in  3  accumulation step index.
REQ-014 en_pe  in  1  issue one MAC operation this cycle.
REQ-015 bound_level  in  3  arithmetic right-shift applied to the result.
REQ-016 step_p  in  3  index of the final step.
REQ-017 en_relu  in  1  ReLU enable.
REQ-018 en_mp  in  1  pairwise max-pool enable.
REQ-019 out  out  64  channel r result = out[63-8r -: 8].
REQ-020 out_en  out  8  per-channel output valid; channel r = out_en[7-r].

Function
REQ-021 Write: each cycle, for every lane j with en_in bit set, SHALL store byte j at mem[write_h][write_w+j]; target columns >= 82 SHALL be ignored; this is independent of en_pe.
REQ-022 Memory map per row r: columns 0..70 hold input data; columns 71..79 hold weight W[r][j] = mem[r][71+j] (signed); bias[r] = {mem[r][80], mem[r][81]} (signed 16-bit).
REQ-023 Stage 1 (en_pe=1): SHALL register A_j = mem[readi_h_j][readi_w_j] (unsigned) when en_read lane j = 1, else 0. SHALL also register all W[r][j], all bias[r], and the control inputs. Reads see pre-write data for a same-cycle write to the same location.
REQ-024 Stage 2: for each r, sum_r = sum over j of A_j*W[r][j], computed signed with A zero-extended. Accumulator acc_r (24-bit signed) SHALL load sum_r + (en_bias ? sign-extended bias[r] : 0) when step=0, else acc_r + sum_r.
REQ-025 Final step: when step == step_p, the updated acc_r is final. Non-final ops produce no output.
REQ-026 Stage 3 post-processing on each final value: v = final >>> bound_level. If en_mp=1, apply REQ-027 before saturation. Then saturate: if en_relu=1, clamp to [0,255]; else clamp to [-128,127] in two's complement.
REQ-027 Max-pool (en_mp=1): the first final of a pair is held internally with no output; the second emits max(held, v) using signed compare. The pair toggle resets when en_mp=0.
REQ-028 Latency: an en_pe final op at cycle t SHALL produce out and out_en=8'hFF at cycle t+3 (registered outputs). out_en is 0 otherwise; out holds its last value.
REQ-029 Back-to-back en_pe every cycle SHALL be supported at full throughput with no stalls.

Reset
REQ-030 reset=1 SHALL clear out, out_en, pipeline valids, accumulators and the max-pool toggle on the next clk edge; memory contents are not cleared.
REQ-031 After reset deasserts, the first valid output SHALL require a new final op.

Verification
REQ-032 Reset asserted 2 cycles -> out=0, out_en=0.
REQ-033 Setup: row0 bias=16'h0010; row0 weights all 1; mem[0][0..8]=2. Issue en_pe, step=0, step_p=0, en_bias=1, bound_level=0, relu=0, lane j reads (col j, row 0), en_read=9'h1FF -> 3 cycles later out_en=8'hFF, channel0=8'h22 (34).
REQ-034 Same as REQ-033 with bound_level=2 -> channel0=8'h08. Two ops with step=0 then step=1, step_p=1, en_bias=0 on the first op -> 36 after the second op only.
REQ-035 Weights all -1 (8'hFF), inputs 100, no bias -> -900 -> 8'h80 with relu=0; 8'h00 with relu=1.
REQ-036 en_mp=1, two finals of 5 then 9 -> single out_en pulse after the second, channel value 9; a write to column 82 leaves memory unchanged; en_read lane0=0 gives A_0=0.
